// File: rtl/packet_arbiter_if.sv
// Handshake bundle between four packet requesters, the arbiter and the shared router.
interface packet_arbiter_if #(
   parameter int PKT_W = 13,
   parameter int CNT_W = 16
);
   logic [3:0]         in_valid;
   logic [4*PKT_W-1:0] in_packet;
   logic [3:0]         in_ready;
   logic               out_valid;
   logic [PKT_W-1:0]   out_packet;
   logic               out_ready;
   logic [1:0]         out_grant;
   logic [CNT_W-1:0]   pkt_cnt;

   modport master (
      output in_valid, in_packet, out_ready,
      input  in_ready, out_valid, out_packet, out_grant, pkt_cnt
   );

   modport slave (
      input  in_valid, in_packet, out_ready,
      output in_ready, out_valid, out_packet, out_grant, pkt_cnt
   );
endinterface

// File: rtl/packet_arbiter.sv
// Four-way round-robin packet arbiter: a requester holds the grant from first beat
// to eop, and beats pass through a single registered output stage.
module packet_arbiter #(
   parameter int PKT_W = 13,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   packet_arbiter_if.slave   bus
);
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state_q, state_d;
   logic [1:0]         rr_q, rr_d;
   logic [1:0]         lock_q, lock_d;
   logic               out_valid_q, out_valid_d;
   logic [PKT_W-1:0]   out_packet_q, out_packet_d;
   logic [1:0]         out_grant_q, out_grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [1:0]         grant;
   logic [1:0]         idx;
   logic               grant_vld;
   logic               load_ok;
   logic               accept;
   logic [PKT_W-1:0]   beat;

   // A locked requester keeps the grant even while its in_valid is low.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      if (state_q == LOCKED) begin
         grant     = lock_q;
         grant_vld = 1'b1;
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!grant_vld && bus.in_valid[idx]) begin
               grant     = idx;
               grant_vld = 1'b1;
            end
         end
      end
   end

   assign load_ok      = !out_valid_q || bus.out_ready;
   assign beat         = bus.in_packet[int'(grant)*PKT_W +: PKT_W];
   assign accept       = grant_vld && bus.in_valid[grant] && load_ok;
   assign bus.in_ready = (grant_vld && load_ok && !reset) ? (4'b0001 << grant) : '0;

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      lock_d       = lock_q;
      out_valid_d  = out_valid_q;
      out_packet_d = out_packet_q;
      out_grant_d  = out_grant_q;
      cnt_d        = cnt_q;

      if (out_valid_q && bus.out_ready && out_packet_q[PKT_W-1] && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);

      if (accept) begin
         out_valid_d  = 1'b1;
         out_packet_d = beat;
         out_grant_d  = grant;
         if (beat[PKT_W-1]) begin
            state_d = IDLE;
            rr_d    = grant + 2'd1;
         end else begin
            state_d = LOCKED;
            lock_d  = grant;
         end
      end else if (load_ok) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         lock_q       <= '0;
         out_valid_q  <= 1'b0;
         out_packet_q <= '0;
         out_grant_q  <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         lock_q       <= lock_d;
         out_valid_q  <= out_valid_d;
         out_packet_q <= out_packet_d;
         out_grant_q  <= out_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_packet = out_packet_q;
   assign bus.out_grant  = out_grant_q;
   assign bus.pkt_cnt    = cnt_q;
endmodule

// File: tb/tb_packet_arbiter.sv
// Bench for packet_arbiter: directed vector table, hand sequences for lock, gap,
// reset and counter saturation, then random traffic against a packet-level model.
module tb_packet_arbiter;
   localparam int PW = 13;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   packet_arbiter_if #(.PKT_W(PW), .CNT_W(16)) ifb ();
   packet_arbiter_if #(.PKT_W(PW), .CNT_W(2))  ifs ();

   assign ifs.in_valid  = ifb.in_valid;
   assign ifs.in_packet = ifb.in_packet;
   assign ifs.out_ready = ifb.out_ready;

   packet_arbiter #(.PKT_W(PW), .CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(ifb.slave));
   packet_arbiter #(.PKT_W(PW), .CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(ifs.slave));

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the link, whose turn is next, what sits in the output slot.
   bit          m_locked;
   int          m_owner;
   int          m_next;
   bit          m_ov;
   logic [12:0] m_op;
   int          m_og;
   int          m_cnt;
   int          m_cnt_s;

   logic [3:0]  last_rdy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_pick(input logic [3:0] v);
      if (m_locked) return m_owner;
      for (int d = 0; d < 4; d++)
         if (v[(m_next + d) % 4]) return (m_next + d) % 4;
      return -1;
   endfunction

   task automatic m_reset();
      m_locked = 0; m_owner = 0; m_next = 0;
      m_ov = 0; m_op = '0; m_og = 0; m_cnt = 0; m_cnt_s = 0;
   endtask

   task automatic drive(input bit r, input logic [3:0] v, input logic [51:0] pk, input bit ordy);
      reset         = r;
      ifb.in_valid  = v;
      ifb.in_packet = pk;
      ifb.out_ready = ordy;
   endtask

   task automatic phase_comb();
      int g;
      bit room;
      logic [3:0] e;
      #1;
      g    = m_pick(ifb.in_valid);
      room = !m_ov || ifb.out_ready;
      e    = (g >= 0 && room && !reset) ? 4'(1 << g) : 4'b0;
      chk("model_in_ready", ifb.in_ready, e);
      last_rdy = ifb.in_ready;
   endtask

   task automatic phase_edge();
      int g;
      bit room;
      logic [12:0] b;
      @(posedge clk);
      if (reset) begin
         m_reset();
      end else begin
         g    = m_pick(ifb.in_valid);
         room = !m_ov || ifb.out_ready;
         if (m_ov && ifb.out_ready && m_op[12]) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
         end
         if (g >= 0 && ifb.in_valid[g] && room) begin
            b    = ifb.in_packet[g*PW +: PW];
            m_ov = 1; m_op = b; m_og = g;
            if (b[12]) begin
               m_locked = 0;
               m_next   = (g + 1) % 4;
            end else begin
               m_locked = 1;
               m_owner  = g;
            end
         end else if (room) begin
            m_ov = 0;
         end
      end
      @(negedge clk);
      chk("model_out_valid", ifb.out_valid, m_ov);
      if (m_ov) begin
         chk("model_out_packet", ifb.out_packet, m_op);
         chk("model_out_grant", ifb.out_grant, m_og);
      end
      chk("model_pkt_cnt", ifb.pkt_cnt, m_cnt);
      chk("model_pkt_cnt_sat", ifs.pkt_cnt, m_cnt_s);
   endtask

   task automatic cyc(input bit r, input logic [3:0] v, input logic [51:0] pk, input bit ordy);
      drive(r, v, pk, ordy);
      phase_comb();
      phase_edge();
   endtask

   typedef struct {
      bit          rst;
      logic [3:0]  v;
      logic [51:0] pk;
      bit          ordy;
      logic [3:0]  e_rdy;
      bit          e_ov;
      logic [12:0] e_op;
      logic [1:0]  e_og;
      int          e_cnt;
   } vec_t;

   function automatic vec_t mk(input bit r, input logic [3:0] v, input logic [51:0] pk,
                               input bit ordy, input logic [3:0] rdy, input bit ov,
                               input logic [12:0] op, input logic [1:0] og, input int cnt);
      vec_t t;
      t.rst = r; t.v = v; t.pk = pk; t.ordy = ordy; t.e_rdy = rdy;
      t.e_ov = ov; t.e_op = op; t.e_og = og; t.e_cnt = cnt;
      return t;
   endfunction

   initial begin
      vec_t        tbl[16];
      logic [51:0] one, rr, pk;
      logic [1:0]  lk_g[4];
      logic [3:0]  lk_v[4];
      logic [51:0] lk_p[4];
      logic [3:0]  rv;

      one = {39'b0, 13'h1AA8};
      rr  = {13'h1033, 13'h1022, 13'h1011, 13'h1000};
      tbl[0]  = mk(1, 4'h0, '0,  1, 4'h0, 0, 13'h0,    0, 0);
      tbl[1]  = mk(0, 4'h1, one, 1, 4'h1, 1, 13'h1AA8, 0, 0);
      tbl[2]  = mk(0, 4'h0, one, 1, 4'h0, 0, 13'h0,    0, 1);
      tbl[3]  = mk(1, 4'hF, rr,  1, 4'h0, 0, 13'h0,    0, 0);
      tbl[4]  = mk(0, 4'hF, rr,  1, 4'h1, 1, 13'h1000, 0, 0);
      tbl[5]  = mk(0, 4'hF, rr,  1, 4'h2, 1, 13'h1011, 1, 1);
      tbl[6]  = mk(0, 4'hF, rr,  1, 4'h4, 1, 13'h1022, 2, 2);
      tbl[7]  = mk(0, 4'hF, rr,  1, 4'h8, 1, 13'h1033, 3, 3);
      tbl[8]  = mk(0, 4'hF, rr,  1, 4'h1, 1, 13'h1000, 0, 4);
      for (int i = 9; i < 14; i++)
         tbl[i] = mk(0, 4'hF, rr, 0, 4'h0, 1, 13'h1000, 0, 4);
      tbl[14] = mk(0, 4'hF, rr,  1, 4'h2, 1, 13'h1011, 1, 5);
      tbl[15] = mk(0, 4'h0, rr,  1, 4'h0, 0, 13'h0,    0, 6);

      m_reset();
      drive(1, 4'h0, '0, 1'b1);
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].pk, tbl[i].ordy);
         phase_comb();
         chk($sformatf("tbl%0d_in_ready", i), last_rdy, tbl[i].e_rdy);
         phase_edge();
         chk($sformatf("tbl%0d_out_valid", i), ifb.out_valid, tbl[i].e_ov);
         if (tbl[i].e_ov) begin
            chk($sformatf("tbl%0d_out_packet", i), ifb.out_packet, tbl[i].e_op);
            chk($sformatf("tbl%0d_out_grant", i), ifb.out_grant, tbl[i].e_og);
         end
         chk($sformatf("tbl%0d_pkt_cnt", i), ifb.pkt_cnt, tbl[i].e_cnt);
      end

      // Port 2 holds the link for its whole packet while port 1 waits.
      lk_v[0] = 4'b0100; lk_p[0] = {13'h0, 13'h0201, 13'h0,    13'h0}; lk_g[0] = 2;
      lk_v[1] = 4'b0110; lk_p[1] = {13'h0, 13'h0202, 13'h1111, 13'h0}; lk_g[1] = 2;
      lk_v[2] = 4'b0110; lk_p[2] = {13'h0, 13'h1203, 13'h1111, 13'h0}; lk_g[2] = 2;
      lk_v[3] = 4'b0010; lk_p[3] = {13'h0, 13'h0,    13'h1111, 13'h0}; lk_g[3] = 1;
      cyc(1, 4'h0, '0, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, lk_v[i], lk_p[i], 1);
         chk($sformatf("lock%0d_rdy1", i), last_rdy[1], (i == 3) ? 1'b1 : 1'b0);
         chk($sformatf("lock%0d_valid", i), ifb.out_valid, 1'b1);
         chk($sformatf("lock%0d_grant", i), ifb.out_grant, lk_g[i]);
      end

      // Port 3 stalls mid-packet: bubbles, nobody else served, then reset clears the lock.
      pk = {13'h0333, 13'h1222, 13'h1111, 13'h1000};
      cyc(1, 4'h0, '0, 1);
      cyc(0, 4'b1000, pk, 1);
      chk("gap_first_grant", ifb.out_grant, 2'd3);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 4'b0111, pk, 1);
         chk($sformatf("gap%0d_rdy", i), last_rdy, 4'b1000);
         chk($sformatf("gap%0d_bubble", i), ifb.out_valid, 1'b0);
      end
      cyc(1, 4'b0111, pk, 1);
      chk("rst_out_valid", ifb.out_valid, 1'b0);
      chk("rst_out_packet", ifb.out_packet, 13'h0);
      chk("rst_out_grant", ifb.out_grant, 2'd0);
      chk("rst_in_ready", last_rdy, 4'b0000);
      cyc(0, 4'b1111, pk, 1);
      chk("post_rst_rdy", last_rdy, 4'b0001);
      chk("post_rst_grant", ifb.out_grant, 2'd0);

      // Two-bit counter saturates at 3.
      cyc(1, 4'h0, '0, 1);
      for (int i = 0; i < 6; i++) begin
         cyc(0, (i < 5) ? 4'b0001 : 4'b0000, {39'b0, 13'h1001}, 1);
         if (i >= 1)
            chk($sformatf("sat%0d", i), ifs.pkt_cnt, (i >= 3) ? 2'd3 : 2'(i));
      end

      for (int n = 0; n < 3000; n++) begin
         for (int l = 0; l < 4; l++) begin
            pk[l*PW +: PW] = PW'($urandom);
            pk[l*PW + PW - 1] = ($urandom_range(0, 2) == 0);
            rv[l] = ($urandom_range(0, 9) < 6);
         end
         cyc(($urandom_range(0, 299) == 0), rv, pk, ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
